pixel_spike_serializer: RTL and testbench
=========================================

Name: pixel_spike_serializer

Overview:
- Sits directly downstream of the digit-pattern auto-trainer, between it and the SNN input layer.
- Captures each one-cycle pattern pulse: a 25-bit 5x5 pixel vector plus a 10-bit one-hot label.
- Replays the pattern as a serial address-event stream: one spike per active pixel, lowest index first, with configurable gaps, followed after a configurable delay by one supervisory label spike.
- A ready handshake lets the downstream layer back-pressure the stream.

Parameters:
- P_PIXELS, 25, width of pixel vector / number of input addresses
- P_CLASSES, 10, width of one-hot label
- P_SPIKE_GAP, 4, idle cycles inserted after each accepted pixel spike (0 = back-to-back)
- P_LABEL_DELAY, 8, idle cycles between the last pixel spike and the label spike (0 allowed)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_test_vector  in  P_PIXELS  pixel pattern, bit n = pixel n (1-based), valid one cycle
- i_label  in  P_CLASSES  one-hot class label, valid same cycle as pattern
- i_end_of_epochs  in  1  training finished; new patterns are ignored while high
- i_ready  in  1  downstream accepts o_spike / o_label_spike this cycle
- o_spike  out  1  pixel spike valid
- o_spike_addr  out  5  pixel address 0..P_PIXELS-1 (bit n maps to n-1)
- o_label_spike  out  1  label spike valid
- o_label_idx  out  4  class index 0..P_CLASSES-1
- o_pix_count  out  5  pixel spikes accepted for the current pattern
- o_busy  out  1  high in any state except IDLE
- o_pattern_done  out  1  one-cycle pulse when a pattern is fully emitted
- o_overrun  out  1  sticky: a pattern arrived while not accepting

Behaviour:
- Reset (asynchronous, i_rst=1): all outputs 0, state IDLE, captured registers and counters 0.
- Upstream drives from the falling edge; this block samples on the rising edge only.
- Pattern present = (|i_test_vector) or (|i_label).
- Capture:
  - Allowed in IDLE or DONE when i_end_of_epochs=0.
  - Latch vector into r_pix and label into r_lab; clear o_pix_count; go to SCAN next cycle.
  - If pattern present in any other state, discard it and set o_overrun (sticky until reset).
  - Pattern present with i_end_of_epochs=1 is ignored silently; no overrun.
- States: IDLE, SCAN, GAP, LDELAY, LABEL, DONE.
- SCAN:
  - If r_pix != 0: o_spike=1, o_spike_addr = index of lowest set bit minus 1.
  - Address and valid hold stable until i_ready=1.
  - On handshake: clear that bit, increment o_pix_count, go to GAP (or stay in SCAN if P_SPIKE_GAP=0).
  - If r_pix == 0: go to LDELAY, with no spike this cycle.
- GAP: count P_SPIKE_GAP cycles, then return to SCAN.
- LDELAY: count P_LABEL_DELAY cycles, then go to LABEL if r_lab != 0, else DONE.
- LABEL:
  - o_label_spike=1, o_label_idx = lowest set bit index of r_lab.
  - Non-one-hot labels use the lowest bit; it is not an error.
  - Hold until i_ready=1, then go to DONE.
- DONE: o_pattern_done=1 for exactly one cycle, then IDLE (capture in this cycle is legal).
- o_spike and o_label_spike are never high together; outputs are registered (Moore).
- Latency: capture edge to first o_spike = 1 cycle.
- Zero-pixel pattern: label only, reached after P_LABEL_DELAY+1 cycles in SCAN/LDELAY.
- All-25-pixel pattern: o_pix_count reaches 25 without wrap (5 bits suffice).
- Counters are sized $clog2(param)+1 and saturate at no value; parameters equal to 0 skip the state.
- i_ready low indefinitely: block stalls, o_busy stays high, and later patterns raise o_overrun.

Decomposition:
- Shared package snn_io_pkg:
  - state enum
  - pixel/class width constants (25, 10)
  - address width constant (5)
- One natural sub-module: lsb_priority_encoder, parameterised width.
  - Returns index of lowest set bit plus a nonzero flag.
  - Instantiated twice: pixel vector and label.

Test Plan:
- Vector 25'h0000005 (pixels 1,3), label bit 4, i_ready=1, gap 4, delay 8:
  - Spikes at addr 0 then 2, 5 cycles apart.
  - Label spike idx 3 nine cycles after the second spike.
  - o_pattern_done next cycle; o_pix_count=2.
- Back-pressure: same pattern with i_ready low 6 cycles on the first spike → o_spike, addr 0 held stable 6 cycles; sequence otherwise unchanged.
- All-ones vector, label bit 1 → 25 spikes addr 0..24 in order; o_pix_count=25, label idx 0, no wrap.
- Zero vector, label bit 10 → no pixel spikes; label idx 9 after 9 cycles; done pulse.
- Second pattern injected mid-SCAN → o_overrun=1 and stays set; first pattern completes unchanged; the pattern injected in the DONE cycle is captured normally.
- i_rst asserted mid-GAP → all outputs 0 immediately (asynchronous); after release, o_busy=0 until a new pattern. A pattern with i_end_of_epochs=1 yields no activity and no overrun.

Source files
------------

// File: rtl/snn_io_pkg.sv
// Shared definitions for the pixel-to-spike serializer slice.
// Holds the serializer FSM state type and the fixed interface widths
// that the upstream trainer and the SNN input layer agree on.
package snn_io_pkg;

  localparam int unsigned PIXELS      = 25;  // 5x5 input image
  localparam int unsigned CLASSES     = 10;  // digit classes
  localparam int unsigned ADDR_W      = 5;   // pixel address 0..24
  localparam int unsigned LABEL_IDX_W = 4;   // class index 0..9
  localparam int unsigned COUNT_W     = 5;   // holds 25 without wrap

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_GAP,
    ST_LDELAY,
    ST_LABEL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Lowest-set-bit priority encoder.
// Ports:
//   vec     - input vector
//   idx     - index of the lowest set bit (0 when vec is zero)
//   nonzero - high when any bit of vec is set
module lsb_priority_encoder #(
  parameter int unsigned P_WIDTH = 25,
  parameter int unsigned P_IDX_W = 5
) (
  input  logic [P_WIDTH-1:0] vec,
  output logic [P_IDX_W-1:0] idx,
  output logic               nonzero
);

  always_comb begin
    idx     = '0;
    nonzero = 1'b0;
    for (int unsigned i = 0; i < P_WIDTH; i++) begin
      if (!nonzero && vec[i]) begin
        idx     = P_IDX_W'(i);
        nonzero = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_spike_serializer.sv
// Serializes a captured 5x5 pixel pattern into an address-event stream,
// lowest pixel first with a configurable gap between spikes, then emits one
// supervisory label spike after a configurable delay.
// Ports:
//   i_clk, i_rst      - clock (rising edge), asynchronous active-high reset
//   i_test_vector     - pixel pattern, valid for one cycle
//   i_label           - one-hot class label, valid with the pattern
//   i_end_of_epochs   - training finished; new patterns are ignored
//   i_ready           - downstream accepts the current spike
//   o_spike/addr      - pixel spike valid and its address
//   o_label_spike/idx - label spike valid and its class index
//   o_pix_count       - pixel spikes accepted for the current pattern
//   o_busy            - any state other than IDLE
//   o_pattern_done    - one-cycle pulse when a pattern is fully emitted
//   o_overrun         - sticky: pattern arrived while not accepting
module pixel_spike_serializer
  import snn_io_pkg::*;
#(
  parameter int unsigned P_PIXELS      = PIXELS,
  parameter int unsigned P_CLASSES     = CLASSES,
  parameter int unsigned P_SPIKE_GAP   = 4,
  parameter int unsigned P_LABEL_DELAY = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [P_PIXELS-1:0]    i_test_vector,
  input  logic [P_CLASSES-1:0]   i_label,
  input  logic                   i_end_of_epochs,
  input  logic                   i_ready,
  output logic                   o_spike,
  output logic [ADDR_W-1:0]      o_spike_addr,
  output logic                   o_label_spike,
  output logic [LABEL_IDX_W-1:0] o_label_idx,
  output logic [COUNT_W-1:0]     o_pix_count,
  output logic                   o_busy,
  output logic                   o_pattern_done,
  output logic                   o_overrun
);

  localparam int unsigned GAP_W = $clog2(P_SPIKE_GAP) + 1;
  localparam int unsigned DLY_W = $clog2(P_LABEL_DELAY) + 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((P_SPIKE_GAP > 0) ? P_SPIKE_GAP - 1 : 0);
  localparam logic [DLY_W-1:0] DLY_LAST =
    DLY_W'((P_LABEL_DELAY > 0) ? P_LABEL_DELAY - 1 : 0);

  state_e                 state, state_next, after_pixels;
  logic [P_PIXELS-1:0]    r_pix, pix_next;
  logic [P_CLASSES-1:0]   r_lab, lab_next;
  logic [GAP_W-1:0]       gap_cnt, gap_next;
  logic [DLY_W-1:0]       dly_cnt, dly_next;
  logic [COUNT_W-1:0]     count_next;
  logic                   overrun_next;
  logic                   pattern_present;
  logic                   accepting;
  logic [ADDR_W-1:0]      pix_idx;
  logic                   pix_nz;
  logic [LABEL_IDX_W-1:0] lab_idx;
  logic                   lab_nz;

  // Encoders look at next-state registers so every output can be registered.
  lsb_priority_encoder #(
    .P_WIDTH(P_PIXELS),
    .P_IDX_W(ADDR_W)
  ) u_pix_enc (
    .vec    (pix_next),
    .idx    (pix_idx),
    .nonzero(pix_nz)
  );

  lsb_priority_encoder #(
    .P_WIDTH(P_CLASSES),
    .P_IDX_W(LABEL_IDX_W)
  ) u_lab_enc (
    .vec    (lab_next),
    .idx    (lab_idx),
    .nonzero(lab_nz)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    pix_next        = r_pix;
    lab_next        = r_lab;
    gap_next        = gap_cnt;
    dly_next        = dly_cnt;
    count_next      = o_pix_count;
    overrun_next    = o_overrun;
    pattern_present = (|i_test_vector) || (|i_label);
    accepting       = (state == ST_IDLE) || (state == ST_DONE);

    // A zero label delay skips LDELAY entirely.
    if (P_LABEL_DELAY > 0) after_pixels = ST_LDELAY;
    else if (|r_lab)       after_pixels = ST_LABEL;
    else                   after_pixels = ST_DONE;

    case (state)
      ST_IDLE: ;
      ST_SCAN: begin
        if (|r_pix) begin
          if (i_ready) begin
            pix_next   = r_pix & (r_pix - 1'b1);  // drop the lowest set bit
            count_next = o_pix_count + 1'b1;
            gap_next   = '0;
            dly_next   = '0;
            // The gap only separates pixel spikes; after the last pixel the
            // label delay starts immediately.
            if (pix_next == '0)       state_next = after_pixels;
            else if (P_SPIKE_GAP > 0) state_next = ST_GAP;
          end
        end else begin
          state_next = after_pixels;
          dly_next   = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = ST_SCAN;
          gap_next   = '0;
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end
      ST_LDELAY: begin
        if (dly_cnt == DLY_LAST) begin
          state_next = (|r_lab) ? ST_LABEL : ST_DONE;
          dly_next   = '0;
        end else begin
          dly_next = dly_cnt + 1'b1;
        end
      end
      ST_LABEL: if (i_ready) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    if (pattern_present && !i_end_of_epochs) begin
      if (accepting) begin
        state_next = ST_SCAN;
        pix_next   = i_test_vector;
        lab_next   = i_label;
        count_next = '0;
      end else begin
        overrun_next = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix          <= '0;
      r_lab          <= '0;
      gap_cnt        <= '0;
      dly_cnt        <= '0;
      o_spike        <= 1'b0;
      o_spike_addr   <= '0;
      o_label_spike  <= 1'b0;
      o_label_idx    <= '0;
      o_pix_count    <= '0;
      o_busy         <= 1'b0;
      o_pattern_done <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      r_pix          <= pix_next;
      r_lab          <= lab_next;
      gap_cnt        <= gap_next;
      dly_cnt        <= dly_next;
      o_spike        <= (state_next == ST_SCAN) && pix_nz;
      o_spike_addr   <= ((state_next == ST_SCAN) && pix_nz) ? pix_idx : '0;
      o_label_spike  <= (state_next == ST_LABEL) && lab_nz;
      o_label_idx    <= (state_next == ST_LABEL) ? lab_idx : '0;
      o_pix_count    <= count_next;
      o_busy         <= (state_next != ST_IDLE);
      o_pattern_done <= (state_next == ST_DONE);
      o_overrun      <= overrun_next;
    end
  end

endmodule

// File: tb/tb_pixel_spike_serializer.sv
// Directed self-checking bench for pixel_spike_serializer (gap 4, delay 8).
// Cycle numbering inside run_stream: cycle c shows the outputs registered at
// the c-th rising edge after the capture edge; inputs change on falling edges.
module tb_pixel_spike_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] vec;
  logic [9:0]  lab;
  logic        eoe;
  logic        ready;
  logic        o_spike;
  logic [4:0]  o_spike_addr;
  logic        o_label_spike;
  logic [3:0]  o_label_idx;
  logic [4:0]  o_pix_count;
  logic        o_busy;
  logic        o_pattern_done;
  logic        o_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  int         spk_cyc[$];
  logic [4:0] spk_addr[$];
  int         lab_cyc, done_cyc, both_high, hold_err, stall_cycles, busy_seen;
  logic [3:0] lab_idx_seen;
  logic [4:0] done_cnt_seen;
  logic       timed_out;

  always #5 clk = ~clk;

  pixel_spike_serializer #(
    .P_PIXELS     (25),
    .P_CLASSES    (10),
    .P_SPIKE_GAP  (4),
    .P_LABEL_DELAY(8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_test_vector  (vec),
    .i_label        (lab),
    .i_end_of_epochs(eoe),
    .i_ready        (ready),
    .o_spike        (o_spike),
    .o_spike_addr   (o_spike_addr),
    .o_label_spike  (o_label_spike),
    .o_label_idx    (o_label_idx),
    .o_pix_count    (o_pix_count),
    .o_busy         (o_busy),
    .o_pattern_done (o_pattern_done),
    .o_overrun      (o_overrun)
  );

  task automatic apply(input logic [24:0] v, input logic [9:0] l);
    @(negedge clk);
    vec = v;
    lab = l;
  endtask

  // Steps until o_pattern_done or max_cyc, recording handshakes.
  task automatic run_stream(input int max_cyc, input int stall_from, input int stall_to,
                            input int inj_a, input int inj_b,
                            input logic [24:0] inj_vec, input logic [9:0] inj_lab);
    logic       prev_stall;
    logic [4:0] prev_addr;
    spk_cyc.delete();
    spk_addr.delete();
    lab_cyc = -1; done_cyc = -1; both_high = 0; hold_err = 0;
    stall_cycles = 0; busy_seen = 0; timed_out = 1'b1;
    lab_idx_seen = '0; done_cnt_seen = '0;
    prev_stall = 1'b0; prev_addr = '0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == inj_a || c == inj_b) begin vec = inj_vec; lab = inj_lab; end
      else begin vec = '0; lab = '0; end
      ready = !(c >= stall_from && c <= stall_to);
      #1;
      if (o_busy) busy_seen++;
      if (o_spike && o_label_spike) both_high++;
      if (prev_stall && (!o_spike || o_spike_addr != prev_addr)) hold_err++;
      if (o_spike && !ready) stall_cycles++;
      prev_stall = o_spike && !ready;
      prev_addr  = o_spike_addr;
      if (o_spike && ready) begin spk_cyc.push_back(c); spk_addr.push_back(o_spike_addr); end
      if (o_label_spike && ready) begin lab_cyc = c; lab_idx_seen = o_label_idx; end
      if (o_pattern_done) begin
        done_cyc = c; done_cnt_seen = o_pix_count; timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({o_spike, o_spike_addr, o_label_spike, o_label_idx, o_pix_count,
         o_busy, o_pattern_done, o_overrun} !== 19'd0) begin
      n_bad++; $display("FAIL reset_outputs: got spike=%b busy=%b ovr=%b want all 0",
                        o_spike, o_busy, o_overrun);
    end
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    apply(25'h0000005, 10'h008);
    run_stream(60, 0, -1, -1, -1, '0, '0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", timed_out); end
    n_cmp++; if (spk_cyc.size() != 2) begin n_bad++; $display("FAIL basic_nspikes: got %0d want 2", spk_cyc.size()); end
    else begin
      n_cmp++; if (spk_cyc[0] != 1 || spk_addr[0] !== 5'd0) begin n_bad++; $display("FAIL basic_spike0: got c%0d a%0d want c1 a0", spk_cyc[0], spk_addr[0]); end
      n_cmp++; if (spk_cyc[1] != 6 || spk_addr[1] !== 5'd2) begin n_bad++; $display("FAIL basic_spike1: got c%0d a%0d want c6 a2", spk_cyc[1], spk_addr[1]); end
    end
    n_cmp++; if (lab_cyc != 15 || lab_idx_seen !== 4'd3) begin n_bad++; $display("FAIL basic_label: got c%0d i%0d want c15 i3", lab_cyc, lab_idx_seen); end
    n_cmp++; if (done_cyc != 16 || done_cnt_seen !== 5'd2) begin n_bad++; $display("FAIL basic_done: got c%0d n%0d want c16 n2", done_cyc, done_cnt_seen); end
    n_cmp++; if (both_high != 0) begin n_bad++; $display("FAIL basic_exclusive: got %0d want 0", both_high); end
    @(negedge clk); #1;
    n_cmp++; if (o_busy !== 1'b0 || o_pattern_done !== 1'b0) begin n_bad++; $display("FAIL basic_idle_after: got busy=%b done=%b want 0 0", o_busy, o_pattern_done); end
  endtask

  task automatic test_back_pressure;
    apply(25'h0000005, 10'h008);
    run_stream(60, 1, 6, -1, -1, '0, '0);
    n_cmp++; if (stall_cycles != 6 || hold_err != 0) begin n_bad++; $display("FAIL bp_hold: got stall=%0d err=%0d want 6 0", stall_cycles, hold_err); end
    n_cmp++; if (spk_cyc.size() != 2) begin n_bad++; $display("FAIL bp_nspikes: got %0d want 2", spk_cyc.size()); end
    else begin
      n_cmp++; if (spk_cyc[0] != 7 || spk_addr[0] !== 5'd0 || spk_cyc[1] != 12 || spk_addr[1] !== 5'd2) begin
        n_bad++; $display("FAIL bp_spikes: got c%0d a%0d c%0d a%0d want c7 a0 c12 a2", spk_cyc[0], spk_addr[0], spk_cyc[1], spk_addr[1]); end
    end
    n_cmp++; if (lab_cyc != 21 || lab_idx_seen !== 4'd3 || done_cyc != 22) begin n_bad++; $display("FAIL bp_label_done: got c%0d i%0d d%0d want c21 i3 d22", lab_cyc, lab_idx_seen, done_cyc); end
  endtask

  task automatic test_all_ones;
    apply(25'h1FFFFFF, 10'h001);
    run_stream(200, 0, -1, -1, -1, '0, '0);
    n_cmp++; if (spk_cyc.size() != 25) begin n_bad++; $display("FAIL ones_nspikes: got %0d want 25", spk_cyc.size()); end
    else begin
      for (int k = 0; k < 25; k++) begin
        n_cmp++; if (spk_addr[k] !== 5'(k) || spk_cyc[k] != 1 + 5 * k) begin
          n_bad++; $display("FAIL ones_spike%0d: got c%0d a%0d want c%0d a%0d", k, spk_cyc[k], spk_addr[k], 1 + 5 * k, k); end
      end
    end
    n_cmp++; if (lab_cyc != 130 || lab_idx_seen !== 4'd0) begin n_bad++; $display("FAIL ones_label: got c%0d i%0d want c130 i0", lab_cyc, lab_idx_seen); end
    n_cmp++; if (done_cyc != 131 || done_cnt_seen !== 5'd25) begin n_bad++; $display("FAIL ones_done: got c%0d n%0d want c131 n25", done_cyc, done_cnt_seen); end
  endtask

  task automatic test_zero_pixels;
    apply(25'h0, 10'h200);
    run_stream(60, 0, -1, -1, -1, '0, '0);
    n_cmp++; if (spk_cyc.size() != 0) begin n_bad++; $display("FAIL zero_nspikes: got %0d want 0", spk_cyc.size()); end
    n_cmp++; if (lab_cyc != 10 || lab_idx_seen !== 4'd9) begin n_bad++; $display("FAIL zero_label: got c%0d i%0d want c10 i9", lab_cyc, lab_idx_seen); end
    n_cmp++; if (done_cyc != 11 || done_cnt_seen !== 5'd0) begin n_bad++; $display("FAIL zero_done: got c%0d n%0d want c11 n0", done_cyc, done_cnt_seen); end
  endtask

  task automatic test_overrun;
    apply(25'h0000005, 10'h008);
    // Foreign pattern during GAP (cycle 3) and again in the DONE cycle (16).
    run_stream(60, 0, -1, 3, 16, 25'h0000010, 10'h002);
    n_cmp++; if (spk_cyc.size() != 2) begin n_bad++; $display("FAIL ovr_nspikes: got %0d want 2", spk_cyc.size()); end
    else begin
      n_cmp++; if (spk_cyc[1] != 6 || spk_addr[1] !== 5'd2) begin n_bad++; $display("FAIL ovr_spike1: got c%0d a%0d want c6 a2", spk_cyc[1], spk_addr[1]); end
    end
    n_cmp++; if (lab_cyc != 15 || lab_idx_seen !== 4'd3 || done_cyc != 16) begin n_bad++; $display("FAIL ovr_first: got c%0d i%0d d%0d want c15 i3 d16", lab_cyc, lab_idx_seen, done_cyc); end
    n_cmp++; if (o_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", o_overrun); end
    run_stream(60, 0, -1, -1, -1, '0, '0);
    n_cmp++; if (spk_cyc.size() != 1) begin n_bad++; $display("FAIL ovr2_nspikes: got %0d want 1", spk_cyc.size()); end
    else begin
      n_cmp++; if (spk_cyc[0] != 1 || spk_addr[0] !== 5'd4) begin n_bad++; $display("FAIL ovr2_spike: got c%0d a%0d want c1 a4", spk_cyc[0], spk_addr[0]); end
    end
    n_cmp++; if (lab_cyc != 10 || lab_idx_seen !== 4'd1 || done_cyc != 11) begin n_bad++; $display("FAIL ovr2_label: got c%0d i%0d d%0d want c10 i1 d11", lab_cyc, lab_idx_seen, done_cyc); end
    n_cmp++; if (o_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", o_overrun); end
  endtask

  task automatic test_reset_mid_gap;
    int busy_after;
    apply(25'h0000005, 10'h008);
    run_stream(3, 0, -1, -1, -1, '0, '0);
    n_cmp++; if (o_busy !== 1'b1 || o_pix_count !== 5'd1) begin n_bad++; $display("FAIL rst_pre: got busy=%b n=%0d want 1 1", o_busy, o_pix_count); end
    #2; rst = 1'b1; #1;
    n_cmp++;
    if ({o_spike, o_spike_addr, o_label_spike, o_label_idx, o_pix_count,
         o_busy, o_pattern_done, o_overrun} !== 19'd0) begin
      n_bad++; $display("FAIL rst_async: got busy=%b n=%0d ovr=%b want all 0", o_busy, o_pix_count, o_overrun);
    end
    @(negedge clk); #1; rst = 1'b0;
    busy_after = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); #1; if (o_busy) busy_after++; end
    n_cmp++; if (busy_after != 0) begin n_bad++; $display("FAIL rst_idle: got %0d busy cycles want 0", busy_after); end
    eoe = 1'b1;
    apply(25'h0000005, 10'h008);
    run_stream(20, 0, -1, -1, -1, '0, '0);
    n_cmp++; if (spk_cyc.size() != 0 || lab_cyc != -1 || busy_seen != 0) begin
      n_bad++; $display("FAIL eoe_ignore: got spikes=%0d lab=%0d busy=%0d want 0 -1 0", spk_cyc.size(), lab_cyc, busy_seen); end
    n_cmp++; if (o_overrun !== 1'b0) begin n_bad++; $display("FAIL eoe_overrun: got %b want 0", o_overrun); end
    eoe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; vec = '0; lab = '0; eoe = 1'b0; ready = 1'b1;
    test_reset;
    test_basic;
    test_back_pressure;
    test_all_ones;
    test_zero_pixels;
    test_overrun;
    test_reset_mid_gap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
